// File: rtl/code_word_unpacker_if.sv
// Handshake bundle between the word source, the unpacker and the float code decoder.
// The master side drives words and the decoder's data_ready; the slave side is the unpacker.
interface code_word_unpacker_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned CODE_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  word_valid;
    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_ready;
    logic                  decode_start;
    logic [CODE_WIDTH-1:0] code_out;
    logic                  data_ready;
    logic                  timeout_error;
    logic [CNT_WIDTH-1:0]  codes_issued;

    modport master (
        output word_valid, word_in, data_ready,
        input  word_ready, decode_start, code_out, timeout_error, codes_issued
    );

    modport slave (
        input  word_valid, word_in, data_ready,
        output word_ready, decode_start, code_out, timeout_error, codes_issued
    );
endinterface

// File: rtl/code_word_unpacker.sv
// Splits packed code words into codes (LSB slot first) and feeds them one at a time to
// the decoder, waiting for data_ready between codes; a watchdog abandons a silent word.
module code_word_unpacker #(
    parameter int unsigned WORD_WIDTH     = 32,
    parameter int unsigned CODE_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input logic                 clock,
    input logic                 reset,
    code_word_unpacker_if.slave bus
);

    localparam int unsigned CODES_PER_WORD = WORD_WIDTH / CODE_WIDTH;
    localparam int unsigned SLOT_W         = (CODES_PER_WORD > 1) ? $clog2(CODES_PER_WORD) : 1;
    localparam int unsigned WAIT_W         = $clog2(TIMEOUT_CYCLES + 1);

    if (WORD_WIDTH % CODE_WIDTH != 0) begin : g_bad_word_width
        $error("code_word_unpacker: WORD_WIDTH must be a multiple of CODE_WIDTH");
    end
    if (TIMEOUT_CYCLES < 3) begin : g_bad_timeout
        $error("code_word_unpacker: TIMEOUT_CYCLES must be at least 3");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                state_q,         state_d;
    logic [WORD_WIDTH-1:0] shift_q,         shift_d;
    logic [SLOT_W-1:0]     slot_q,          slot_d;
    logic [WAIT_W-1:0]     wait_cnt_q,      wait_cnt_d;
    logic                  word_ready_q,    word_ready_d;
    logic                  decode_start_q,  decode_start_d;
    logic [CODE_WIDTH-1:0] code_out_q,      code_out_d;
    logic                  timeout_error_q, timeout_error_d;
    logic [CNT_WIDTH-1:0]  codes_issued_q,  codes_issued_d;

    logic last_slot;
    logic wait_expired;

    assign last_slot    = (slot_q == SLOT_W'(CODES_PER_WORD - 1));
    assign wait_expired = ((wait_cnt_q + WAIT_W'(1)) == WAIT_W'(TIMEOUT_CYCLES));

    // Next-state and registered-output logic; decode_start defaults low so it only pulses.
    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        slot_d          = slot_q;
        wait_cnt_d      = wait_cnt_q;
        word_ready_d    = word_ready_q;
        decode_start_d  = 1'b0;
        code_out_d      = code_out_q;
        timeout_error_d = timeout_error_q;
        codes_issued_d  = codes_issued_q;

        unique case (state_q)
            IDLE: begin
                word_ready_d = 1'b1;
                if (bus.word_valid && word_ready_q) begin
                    shift_d      = bus.word_in;
                    slot_d       = '0;
                    word_ready_d = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                decode_start_d = 1'b1;
                code_out_d     = shift_q[CODE_WIDTH-1:0];
                codes_issued_d = codes_issued_q + CNT_WIDTH'(1);
                wait_cnt_d     = '0;
                state_d        = WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                // An answer on the expiry cycle still counts as an answer.
                if (bus.data_ready) begin
                    if (last_slot) begin
                        word_ready_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        shift_d = shift_q >> CODE_WIDTH;
                        slot_d  = slot_q + SLOT_W'(1);
                        state_d = ISSUE;
                    end
                end else if (wait_expired) begin
                    timeout_error_d = 1'b1;
                    word_ready_d    = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            shift_q         <= '0;
            slot_q          <= '0;
            wait_cnt_q      <= '0;
            word_ready_q    <= 1'b0;
            decode_start_q  <= 1'b0;
            code_out_q      <= '0;
            timeout_error_q <= 1'b0;
            codes_issued_q  <= '0;
        end else begin
            state_q         <= state_d;
            shift_q         <= shift_d;
            slot_q          <= slot_d;
            wait_cnt_q      <= wait_cnt_d;
            word_ready_q    <= word_ready_d;
            decode_start_q  <= decode_start_d;
            code_out_q      <= code_out_d;
            timeout_error_q <= timeout_error_d;
            codes_issued_q  <= codes_issued_d;
        end
    end

    assign bus.word_ready    = word_ready_q;
    assign bus.decode_start  = decode_start_q;
    assign bus.code_out      = code_out_q;
    assign bus.timeout_error = timeout_error_q;
    assign bus.codes_issued  = codes_issued_q;

endmodule
